mouse_status_formatter: RTL
===========================

Name: mouse_status_formatter

Overview:
Converts live PS/2 mouse state into a 32-bit, 8-digit word for the serial seven-segment driver, with paged views, hex or decimal rendering, click counters, a hold (freeze) mode and a periodic refresh strobe.
Sits between the PS/2 mouse driver and the seven-segment driver, replacing ad-hoc bit concatenation at the top level.
Decimal rendering uses a sequential shift-and-add-3 converter.

Parameters:
X_W, 10, x_pos width (1..14)
Y_W, 9, y_pos width (1..14)
CNT_W, 16, click counter width (1..16), saturating
REFRESH_DIV, 1048576, clk cycles between refresh ticks (>=40)
DEBOUNCE_CYC, 500000, cycles page_btn must be stable to register (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
x_pos  in  X_W  cursor x from mouse driver
y_pos  in  Y_W  cursor y from mouse driver
left_btn  in  1  left button level
right_btn  in  1  right button level
page_btn  in  1  raw, asynchronous push-button; debounced rising edge advances page
dec_mode  in  1  1 = decimal rendering for pages 0/1, 0 = hex
hold  in  1  1 = freeze display word
clr_cnt  in  1  synchronous pulse, clears both click counters
hexs  out  32  display word, digit 7 = bits 31:28
points  out  8  decimal-point mask
start  out  1  one-cycle strobe to the segment driver after hexs changes
page  out  2  current page 0..2
busy  out  1  high while capture/conversion is in progress

Behaviour:
- Reset, asynchronous on rst_n low: hexs=0, points=8'h80, start=0, page=0, busy=0, counters=0, frame counter=0, FSM=IDLE, refresh divider=0. Applies mid-conversion with no partial output.
- Inputs page_btn, left_btn and right_btn pass through 2-flop synchronisers.
- Debounce: page_btn must be stable for DEBOUNCE_CYC cycles before the debounced level updates. Each debounced rising edge advances page: 0->1->2->0. The new page is used at the next SNAP.
- Click counters: a synchronised rising edge of left_btn or right_btn increments the matching counter. Counters saturate at 2^CNT_W-1. If clr_cnt and an edge occur in the same cycle, clear wins. Counting continues during hold.
- Refresh: the divider produces a 1-cycle tick every REFRESH_DIV cycles.
  - A tick in IDLE with hold=0 starts a capture.
  - A tick while busy=1 or while hold=1 is dropped; there is no queueing.
- FSM states: IDLE, SNAP, CONV_A, CONV_B, LOAD.
  - IDLE -> SNAP on accepted tick. busy is high from SNAP through LOAD.
  - SNAP (1 cycle): latches page, dec_mode, x, y, both counters and button levels.
    - Goes to CONV_A if dec_mode=1 and page is 0 or 1; otherwise goes to LOAD.
  - CONV_A (16 cycles): converts operand A (x for page 0, left count for page 1), one bit per cycle.
  - CONV_B (16 cycles): same conversion for operand B (y for page 0, right count for page 1).
  - LOAD (1 cycle): writes hexs and points, increments the 16-bit wrapping frame counter, returns to IDLE.
  - start=1 for exactly the cycle after LOAD.
- Latency from accepted tick to start: hex mode 3 cycles; decimal mode 35 cycles.
- Page layouts:
  - Page 0, hex: hexs[31:16] = x_pos zero-extended, hexs[15:0] = y_pos zero-extended.
  - Page 0, dec: hexs[31:16] = 4 BCD digits of x, hexs[15:0] = 4 BCD digits of y.
  - Page 1: same as page 0 with left count (upper half) and right count (lower half).
  - Page 2, always hex: {3'b0,left,3'b0,right,8'h00,frame_cnt[15:0]}.
- Decimal saturation: operands above 9999 are clamped to 9999 before conversion.
- points: one-hot, bit (7-page) set. Bit 0 is additionally set in decimal mode on pages 0/1.
- hold: while high, hexs and points are frozen. A capture already in flight completes normally.

Test Plan:
- Reset mid-CONV_A, dec_mode=1 -> all outputs at reset values on the same edge; the next accepted tick re-runs the full 35-cycle capture.
- Hex mode, page 0, x=10'h2A5, y=9'h1C3 -> hexs=32'h02A5_01C3, points=8'h80, start pulse 3 cycles after tick.
- dec_mode=1, x=1023, y=480 -> hexs=32'h1023_0480, points=8'h81, start 35 cycles after tick, ticks during busy dropped.
- Page 1 after one debounced page_btn press; 3 left clicks, 70000 right clicks with CNT_W=16 -> dec: 32'h0003_9999; hex: 32'h0003_FFFF; clr_cnt coincident with a left edge -> 32'h0000_0000.
- page_btn glitch shorter than DEBOUNCE_CYC -> page unchanged; three clean presses -> page 1, 2, 0; page 2 shows {4'h1,4'h0,8'h00,frame_cnt} with left held and right released.
- hold=1 across 3 ticks with x changing -> hexs and points unchanged, no start pulses; hold released -> next tick updates hexs.

Source files
------------

// File: rtl/mouse_status_formatter.sv
// Formats live PS/2 mouse state into an 8-digit word for the seven-segment driver.
// Supports paged views, hex or BCD rendering, click counters, a hold mode and a refresh strobe.
module mouse_status_formatter #(
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int CNT_W        = 16,
    parameter int REFRESH_DIV  = 1048576,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [X_W-1:0]   x_pos,
    input  logic [Y_W-1:0]   y_pos,
    input  logic             left_btn,
    input  logic             right_btn,
    input  logic             page_btn,
    input  logic             dec_mode,
    input  logic             hold,
    input  logic             clr_cnt,
    output logic [31:0]      hexs,
    output logic [7:0]       points,
    output logic             start,
    output logic [1:0]       page,
    output logic             busy
);

    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam int DB_W  = $clog2(DEBOUNCE_CYC);

    typedef enum logic [2:0] {S_IDLE, S_SNAP, S_CONV_A, S_CONV_B, S_LOAD} state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               w_load;

    logic [DIV_W-1:0]   r_div;
    logic               w_tick;

    logic [1:0]         r_pageSync;
    logic [1:0]         r_leftSync;
    logic [1:0]         r_rightSync;
    logic               r_leftPrev;
    logic               r_rightPrev;
    logic               w_leftEdge;
    logic               w_rightEdge;

    logic [DB_W-1:0]    r_dbCnt;
    logic               r_dbLevel;
    logic [1:0]         r_page;

    logic [CNT_W-1:0]   r_leftCnt;
    logic [CNT_W-1:0]   r_rightCnt;

    logic [1:0]         r_snapPage;
    logic               r_snapDec;
    logic               r_snapL;
    logic               r_snapR;
    logic [X_W-1:0]     r_snapX;
    logic [Y_W-1:0]     r_snapY;
    logic [CNT_W-1:0]   r_snapLeftCnt;
    logic [CNT_W-1:0]   r_snapRightCnt;

    logic [3:0]         r_bitCnt;
    logic [15:0]        r_bcd;
    logic [15:0]        r_bin;
    logic [15:0]        r_bcdA;
    logic [31:0]        w_step;

    logic [15:0]        r_frameCnt;
    logic [31:0]        r_hexs;
    logic [7:0]         r_points;
    logic               r_start;
    logic [31:0]        w_nextHexs;
    logic [7:0]         w_nextPoints;
    logic               w_useDec;

    function automatic logic [15:0] clamp9999(input logic [15:0] v);
        return (v > 16'd9999) ? 16'd9999 : v;
    endfunction

    // One shift-and-add-3 iteration: returns {bcd, bin} after the shift.
    function automatic logic [31:0] dabble(input logic [15:0] bcd, input logic [15:0] bin);
        logic [15:0] adj;
        adj = bcd;
        for (int d = 0; d < 4; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj[14:0], bin[15], bin[14:0], 1'b0};
    endfunction

    assign w_tick      = (r_div == DIV_W'(REFRESH_DIV - 1));
    assign w_leftEdge  = r_leftSync[1] & ~r_leftPrev;
    assign w_rightEdge = r_rightSync[1] & ~r_rightPrev;
    assign w_step      = dabble(r_bcd, r_bin);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pageSync  <= '0;
            r_leftSync  <= '0;
            r_rightSync <= '0;
            r_leftPrev  <= 1'b0;
            r_rightPrev <= 1'b0;
        end else begin
            r_pageSync  <= {r_pageSync[0], page_btn};
            r_leftSync  <= {r_leftSync[0], left_btn};
            r_rightSync <= {r_rightSync[0], right_btn};
            r_leftPrev  <= r_leftSync[1];
            r_rightPrev <= r_rightSync[1];
        end
    end

    // The page advances only when the debounced level commits to high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbCnt   <= '0;
            r_dbLevel <= 1'b0;
            r_page    <= 2'd0;
        end else if (r_pageSync[1] == r_dbLevel) begin
            r_dbCnt <= '0;
        end else if (r_dbCnt == DB_W'(DEBOUNCE_CYC - 1)) begin
            r_dbCnt   <= '0;
            r_dbLevel <= r_pageSync[1];
            if (r_pageSync[1]) r_page <= (r_page == 2'd2) ? 2'd0 : r_page + 2'd1;
        end else begin
            r_dbCnt <= r_dbCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leftCnt  <= '0;
            r_rightCnt <= '0;
        end else if (clr_cnt) begin
            r_leftCnt  <= '0;
            r_rightCnt <= '0;
        end else begin
            if (w_leftEdge && (r_leftCnt != '1))   r_leftCnt  <= r_leftCnt + 1'b1;
            if (w_rightEdge && (r_rightCnt != '1)) r_rightCnt <= r_rightCnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:   if (w_tick && !hold) w_nextState = S_SNAP;
            S_SNAP:   w_nextState = (dec_mode && (r_page != 2'd2)) ? S_CONV_A : S_LOAD;
            S_CONV_A: if (r_bitCnt == 4'd15) w_nextState = S_CONV_B;
            S_CONV_B: if (r_bitCnt == 4'd15) w_nextState = S_LOAD;
            S_LOAD:   w_nextState = S_IDLE;
            default:  w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != S_IDLE);
        w_load = (r_state == S_LOAD);
    end

    // Operand A is loaded from live inputs at SNAP; operand B swaps in after the 16th step of A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snapPage     <= 2'd0;
            r_snapDec      <= 1'b0;
            r_snapL        <= 1'b0;
            r_snapR        <= 1'b0;
            r_snapX        <= '0;
            r_snapY        <= '0;
            r_snapLeftCnt  <= '0;
            r_snapRightCnt <= '0;
            r_bitCnt       <= 4'd0;
            r_bcd          <= 16'd0;
            r_bin          <= 16'd0;
            r_bcdA         <= 16'd0;
        end else begin
            case (r_state)
                S_SNAP: begin
                    r_snapPage     <= r_page;
                    r_snapDec      <= dec_mode;
                    r_snapL        <= r_leftSync[1];
                    r_snapR        <= r_rightSync[1];
                    r_snapX        <= x_pos;
                    r_snapY        <= y_pos;
                    r_snapLeftCnt  <= r_leftCnt;
                    r_snapRightCnt <= r_rightCnt;
                    r_bitCnt       <= 4'd0;
                    r_bcd          <= 16'd0;
                    r_bin          <= clamp9999((r_page == 2'd0) ? 16'(x_pos) : 16'(r_leftCnt));
                end
                S_CONV_A: begin
                    r_bitCnt <= r_bitCnt + 4'd1;
                    if (r_bitCnt == 4'd15) begin
                        r_bcdA <= w_step[31:16];
                        r_bcd  <= 16'd0;
                        r_bin  <= clamp9999((r_snapPage == 2'd0) ? 16'(r_snapY) : 16'(r_snapRightCnt));
                    end else begin
                        {r_bcd, r_bin} <= w_step;
                    end
                end
                S_CONV_B: begin
                    r_bitCnt       <= r_bitCnt + 4'd1;
                    {r_bcd, r_bin} <= w_step;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_useDec     = r_snapDec && (r_snapPage != 2'd2);
        w_nextHexs   = 32'd0;
        w_nextPoints = (8'h80 >> r_snapPage) | {7'd0, w_useDec};
        if (r_snapPage == 2'd2) begin
            w_nextHexs = {3'b000, r_snapL, 3'b000, r_snapR, 8'h00, r_frameCnt};
        end else if (w_useDec) begin
            w_nextHexs = {r_bcdA, r_bcd};
        end else if (r_snapPage == 2'd0) begin
            w_nextHexs = {16'(r_snapX), 16'(r_snapY)};
        end else begin
            w_nextHexs = {16'(r_snapLeftCnt), 16'(r_snapRightCnt)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hexs     <= 32'd0;
            r_points   <= 8'h80;
            r_frameCnt <= 16'd0;
            r_start    <= 1'b0;
        end else begin
            r_start <= w_load;
            if (w_load) begin
                r_hexs     <= w_nextHexs;
                r_points   <= w_nextPoints;
                r_frameCnt <= r_frameCnt + 16'd1;
            end
        end
    end

    assign hexs   = r_hexs;
    assign points = r_points;
    assign start  = r_start;
    assign page   = r_page;

endmodule
